// File: rtl/cci_mpf_shim_rd_tag_remap.sv
// Channel-0 read tag remapper: swaps AFU mdata for a dense internal tag on the
// way to QLP and restores the original mdata on the buffered response.
module cci_mpf_shim_rd_tag_remap #(
   parameter int MDATA_WIDTH       = 13,
   parameter int HDR_OTHER_WIDTH   = 48,
   parameter int CCI_DATA_WIDTH    = 512,
   parameter int N_TAGS            = 64,
   parameter int ALMFULL_THRESHOLD = 4
) (
   input  logic                       clk,
   input  logic                       resetb,
   input  logic                       afu_c0_tx_rd_valid,
   input  logic [MDATA_WIDTH-1:0]     afu_c0_tx_mdata,
   input  logic [HDR_OTHER_WIDTH-1:0] afu_c0_tx_hdr_other,
   output logic                       afu_c0_tx_almfull,
   output logic                       qlp_c0_tx_rd_valid,
   output logic [MDATA_WIDTH-1:0]     qlp_c0_tx_mdata,
   output logic [HDR_OTHER_WIDTH-1:0] qlp_c0_tx_hdr_other,
   input  logic                       qlp_c0_tx_almfull,
   input  logic                       raw_c0_rx_rd_valid,
   input  logic [MDATA_WIDTH-1:0]     raw_c0_rx_mdata,
   input  logic                       buf_c0_rx_rd_valid,
   input  logic [MDATA_WIDTH-1:0]     buf_c0_rx_mdata,
   input  logic [CCI_DATA_WIDTH-1:0]  buf_c0_rx_data,
   output logic                       afu_c0_rx_rd_valid,
   output logic [MDATA_WIDTH-1:0]     afu_c0_rx_mdata,
   output logic [CCI_DATA_WIDTH-1:0]  afu_c0_rx_data,
   output logic                       err_unexpected_rsp
);

   localparam int TAG_BITS = $clog2(N_TAGS);

   logic [N_TAGS-1:0]          busy_q, busy_d;
   logic [TAG_BITS:0]          free_cnt_q, free_cnt_d;
   logic [TAG_BITS-1:0]        alloc_tag;
   logic                       alloc_en, free_en, rsp_bad;
   logic [TAG_BITS-1:0]        rsp_tag, raw_tag;
   logic                       rsp_hi, raw_hi;
   logic                       tx_valid_q;
   logic [TAG_BITS-1:0]        tx_tag_q;
   logic [HDR_OTHER_WIDTH-1:0] tx_hdr_q;
   logic                       err_q;
   logic [MDATA_WIDTH-1:0]     mdata_ram [N_TAGS];
   logic [MDATA_WIDTH-1:0]     rd_mdata_q;

   assign rsp_tag = buf_c0_rx_mdata[TAG_BITS-1:0];
   assign raw_tag = raw_c0_rx_mdata[TAG_BITS-1:0];

   generate
      if (MDATA_WIDTH > TAG_BITS) begin : g_upper
         assign rsp_hi = |buf_c0_rx_mdata[MDATA_WIDTH-1:TAG_BITS];
         assign raw_hi = |raw_c0_rx_mdata[MDATA_WIDTH-1:TAG_BITS];
      end else begin : g_no_upper
         assign rsp_hi = 1'b0;
         assign raw_hi = 1'b0;
      end
   endgenerate

   // Lowest free tag wins; scanning downward leaves the smallest index last.
   always_comb begin
      alloc_tag = '0;
      for (int i = N_TAGS - 1; i >= 0; i--) begin
         if (!busy_q[i]) alloc_tag = TAG_BITS'(i);
      end
   end

   assign alloc_en = afu_c0_tx_rd_valid && (free_cnt_q != '0);
   // Only a response for a live, in-range tag returns it to the pool.
   assign free_en  = buf_c0_rx_rd_valid && !rsp_hi && busy_q[rsp_tag];
   assign rsp_bad  = buf_c0_rx_rd_valid && !free_en;

   always_comb begin
      busy_d = busy_q;
      if (free_en)  busy_d[rsp_tag]   = 1'b0;
      if (alloc_en) busy_d[alloc_tag] = 1'b1;
   end

   always_comb begin
      free_cnt_d = free_cnt_q;
      case ({alloc_en, free_en})
         2'b10:   free_cnt_d = free_cnt_q - (TAG_BITS+1)'(1);
         2'b01:   free_cnt_d = free_cnt_q + (TAG_BITS+1)'(1);
         default: free_cnt_d = free_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         busy_q     <= '0;
         free_cnt_q <= (TAG_BITS+1)'(N_TAGS);
         tx_valid_q <= 1'b0;
         tx_tag_q   <= '0;
         tx_hdr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         free_cnt_q <= free_cnt_d;
         tx_valid_q <= alloc_en;
         if (alloc_en) begin
            tx_tag_q <= alloc_tag;
            tx_hdr_q <= afu_c0_tx_hdr_other;
         end
         err_q      <= err_q | rsp_bad;
      end
   end

   // Tag store; the read is launched from the raw response so it lines up with the buffered one.
   always_ff @(posedge clk) begin
      if (alloc_en) mdata_ram[alloc_tag] <= afu_c0_tx_mdata;
      if (raw_c0_rx_rd_valid && !raw_hi) rd_mdata_q <= mdata_ram[raw_tag];
   end

   assign afu_c0_tx_almfull   = qlp_c0_tx_almfull ||
                                (free_cnt_q <= (TAG_BITS+1)'(ALMFULL_THRESHOLD));
   assign qlp_c0_tx_rd_valid  = tx_valid_q;
   assign qlp_c0_tx_mdata     = MDATA_WIDTH'(tx_tag_q);
   assign qlp_c0_tx_hdr_other = tx_hdr_q;
   assign afu_c0_rx_rd_valid  = buf_c0_rx_rd_valid;
   assign afu_c0_rx_data      = buf_c0_rx_data;
   assign afu_c0_rx_mdata     = rd_mdata_q;
   assign err_unexpected_rsp  = err_q;

   a_no_req_when_full: assert property (@(posedge clk) disable iff (!resetb)
      !(afu_c0_tx_rd_valid && (free_cnt_q == '0)));

endmodule

// File: doc/cci_mpf_shim_rd_tag_remap.md
Name: cci_mpf_shim_rd_tag_remap

Overview:
- Channel-0 read tag remapper on the QLP side of the MPF shim stack.
- Replaces each AFU read-request mdata with a dense internal tag and stores the original mdata in block RAM indexed by that tag.
- Restores the original mdata on the response. The RAM lookup starts from the unbuffered (raw) response and its result is consumed alongside the one-cycle-delayed (buffered) response produced by the QLP RX buffer stage.
- Frees the tag when the response retires.

Parameters:
- MDATA_WIDTH, 13, width of AFU-visible mdata/tag field.
- HDR_OTHER_WIDTH, 48, non-mdata request header bits; passed through untouched.
- CCI_DATA_WIDTH, 512, response data width.
- N_TAGS, 64, internal tag count; power of 2, at most 2^MDATA_WIDTH. TAG_BITS = log2(N_TAGS).
- ALMFULL_THRESHOLD, 4, assert AFU almfull when free tags <= this value.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- afu_c0_tx_rd_valid  in  1  AFU read request valid
- afu_c0_tx_mdata  in  MDATA_WIDTH  AFU request mdata
- afu_c0_tx_hdr_other  in  HDR_OTHER_WIDTH  remaining request header
- afu_c0_tx_almfull  out  1  back-pressure to AFU
- qlp_c0_tx_rd_valid  out  1  request to QLP
- qlp_c0_tx_mdata  out  MDATA_WIDTH  internal tag, zero-extended
- qlp_c0_tx_hdr_other  out  HDR_OTHER_WIDTH  passed header
- qlp_c0_tx_almfull  in  1  QLP back-pressure
- raw_c0_rx_rd_valid  in  1  unbuffered response valid (lookup trigger)
- raw_c0_rx_mdata  in  MDATA_WIDTH  unbuffered response mdata
- buf_c0_rx_rd_valid  in  1  response valid delayed exactly 1 cycle
- buf_c0_rx_mdata  in  MDATA_WIDTH  delayed response mdata
- buf_c0_rx_data  in  CCI_DATA_WIDTH  delayed response data
- afu_c0_rx_rd_valid  out  1  response to AFU
- afu_c0_rx_mdata  out  MDATA_WIDTH  restored original mdata
- afu_c0_rx_data  out  CCI_DATA_WIDTH  response data
- err_unexpected_rsp  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync deassert use):
  - All qlp_c0_tx_* outputs 0; err_unexpected_rsp 0.
  - busy[N_TAGS] all 0; free_cnt = N_TAGS.
  - afu_c0_tx_almfull = qlp_c0_tx_almfull (0 tags used).
  - Reset mid-operation discards all outstanding tags. Responses arriving after reset are unexpected (see error rule).
- Allocation:
  - alloc_tag = lowest index with busy == 0 (priority encoder).
  - On afu_c0_tx_rd_valid, in the same cycle: set busy[alloc_tag] and write RAM[alloc_tag] = afu_c0_tx_mdata.
  - Next cycle: qlp_c0_tx_rd_valid = 1, qlp_c0_tx_mdata = alloc_tag, hdr_other registered.
  - TX latency is exactly 1 cycle; otherwise qlp_c0_tx_rd_valid = 0.
- Almfull:
  - afu_c0_tx_almfull = qlp_c0_tx_almfull OR (free_cnt <= ALMFULL_THRESHOLD). Combinational from registered free_cnt.
  - A request with free_cnt == 0 is an AFU protocol violation: simulation assertion fires, request dropped, state unchanged.
- Lookup:
  - raw_c0_rx_rd_valid drives RAM read address raw_c0_rx_mdata[TAG_BITS-1:0].
  - RAM output is registered and aligns with buf_c0_rx_* in the following cycle.
- Response:
  - afu_c0_rx_rd_valid = buf_c0_rx_rd_valid; afu_c0_rx_data = buf_c0_rx_data; afu_c0_rx_mdata = RAM read data. All combinational, 0 added latency from the buffered side.
- Free:
  - On buf_c0_rx_rd_valid, clear busy[buf_c0_rx_mdata[TAG_BITS-1:0]] at the clock edge.
  - A tag freed in cycle t is allocatable from t+1; no same-cycle bypass.
- free_cnt: +1 on free, -1 on allocate, unchanged on both or neither. Never exceeds N_TAGS and never underflows.
- Error: buf response whose tag has busy == 0, or whose upper mdata bits (above TAG_BITS) are nonzero -> err_unexpected_rsp set until reset. Response is still forwarded; restored mdata is undefined.
- RAM hazard: the write at allocation always precedes the raw response by at least 2 cycles, so no read/write bypass is required.
- Responses may return in any order.

Test Plan:
- Single read, mdata 0x1ABC after reset -> qlp tx 1 cycle later with mdata 0x0000. Response with tag 0 -> AFU sees mdata 0x1ABC; free_cnt returns to 64.
- 60 back-to-back requests -> tags 0..59 in order. afu_c0_tx_almfull rises the cycle free_cnt reaches 4 (after 60th).
- Out-of-order returns for tags 5, 2, 40 carrying mdata 0x005, 0x102, 0x7FF -> each original mdata restored. Next allocation picks tag 2.
- Same cycle: allocate while tag 7 frees, with tags 0..6 busy and tag 7 lowest-free-after-free -> new request gets tag 8, not 7; free_cnt unchanged; tag 7 granted next cycle.
- Response with tag 9 never allocated -> err_unexpected_rsp = 1 and stays 1; data still forwarded.
- resetb pulsed low with 10 tags outstanding -> free_cnt = 64, all tx outputs 0 immediately. A later response for a stale tag sets err_unexpected_rsp.
